ahb_lite_uart_master: RTL and testbench

//  Debug bridge acting as an AHB-Lite master. It parses a byte command stream (from a UART receiver

---
 rtl/ahb_lite_uart_master.sv | 187 ++++++++++++++++++
 tb/tb_ahb_lite_uart_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_uart_master.sv
// Debug bridge: parses a UART byte command stream and issues single-word AHB-Lite reads and writes,
// returning write acks, read data or error bytes on a UART transmit byte stream.
module ahb_lite_uart_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   output logic [31:0] HADDR,
   output logic [2:0]  HBURST,
   output logic        HMASTLOCK,
   output logic [3:0]  HPROT,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   output logic        RX_READY,
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   output logic        BUSY
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_CMD   = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_WDATA = 3'd2;
   localparam logic [2:0] S_APH   = 3'd3;
   localparam logic [2:0] S_DPH   = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   localparam logic [7:0] CH_W   = 8'h57;
   localparam logic [7:0] CH_R   = 8'h52;
   localparam logic [7:0] CH_OK  = 8'h4B;
   localparam logic [7:0] CH_ERR = 8'h45;

   assign HBURST    = 3'b000;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = 4'b0011;
   assign HSIZE     = 3'b010;

   logic [2:0]    state_q, state_n;
   logic [1:0]    cnt_q, cnt_n;
   logic [TW-1:0] tmo_q, tmo_n;
   logic [31:0]   addr_q, addr_n;
   logic [31:0]   rdata_q, rdata_n;
   logic [31:0]   haddr_n, hwdata_n;
   logic [1:0]    htrans_n;
   logic          hwrite_n, rx_ready_n, tx_valid_n, busy_n, rx_fire;
   logic [7:0]    tx_data_n;

   // State and registered outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= S_CMD;
         cnt_q    <= 2'd0;
         tmo_q    <= '0;
         addr_q   <= 32'd0;
         rdata_q  <= 32'd0;
         HADDR    <= 32'd0;
         HTRANS   <= TR_IDLE;
         HWRITE   <= 1'b0;
         HWDATA   <= 32'd0;
         RX_READY <= 1'b1;
         TX_DATA  <= 8'd0;
         TX_VALID <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         tmo_q    <= tmo_n;
         addr_q   <= addr_n;
         rdata_q  <= rdata_n;
         HADDR    <= haddr_n;
         HTRANS   <= htrans_n;
         HWRITE   <= hwrite_n;
         HWDATA   <= hwdata_n;
         RX_READY <= rx_ready_n;
         TX_DATA  <= tx_data_n;
         TX_VALID <= tx_valid_n;
         BUSY     <= busy_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q;
      tmo_n      = tmo_q;
      addr_n     = addr_q;
      rdata_n    = rdata_q;
      haddr_n    = HADDR;
      hwrite_n   = HWRITE;
      hwdata_n   = HWDATA;
      tx_data_n  = TX_DATA;
      tx_valid_n = TX_VALID;
      rx_fire    = RX_VALID & RX_READY;

      case (state_q)
         S_CMD: begin
            if (rx_fire && (RX_DATA == CH_W || RX_DATA == CH_R)) begin
               hwrite_n = (RX_DATA == CH_W);
               cnt_n    = 2'd0;
               tmo_n    = TW'(TIMEOUT_CYCLES);
               state_n  = S_ADDR;
            end
         end
         S_ADDR: begin
            if (rx_fire) begin
               addr_n = {addr_q[23:0], RX_DATA};
               tmo_n  = TW'(TIMEOUT_CYCLES);
               cnt_n  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  haddr_n = {addr_n[31:2], 2'b00};
                  state_n = HWRITE ? S_WDATA : S_APH;
               end
            end else if (tmo_q == '0) begin
               cnt_n   = 2'd0;
               state_n = S_CMD;
            end else begin
               tmo_n = tmo_q - TW'(1);
            end
         end
         S_WDATA: begin
            if (rx_fire) begin
               hwdata_n = {HWDATA[23:0], RX_DATA};
               tmo_n    = TW'(TIMEOUT_CYCLES);
               cnt_n    = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_n = S_APH;
            end else if (tmo_q == '0) begin
               cnt_n   = 2'd0;
               state_n = S_CMD;
            end else begin
               tmo_n = tmo_q - TW'(1);
            end
         end
         S_APH: begin
            if (HREADY) state_n = S_DPH;
         end
         S_DPH: begin
            // HRESP is only meaningful on the completing (HREADY=1) cycle
            if (HREADY) begin
               state_n    = S_RESP;
               tx_valid_n = 1'b1;
               rdata_n    = {HRDATA[23:0], 8'h00};
               if (HRESP) begin
                  tx_data_n = CH_ERR;
                  cnt_n     = 2'd3;
               end else if (HWRITE) begin
                  tx_data_n = CH_OK;
                  cnt_n     = 2'd3;
               end else begin
                  tx_data_n = HRDATA[31:24];
                  cnt_n     = 2'd0;
               end
            end
         end
         S_RESP: begin
            if (TX_READY) begin
               if (cnt_q == 2'd3) begin
                  tx_valid_n = 1'b0;
                  cnt_n      = 2'd0;
                  state_n    = S_CMD;
               end else begin
                  tx_data_n = rdata_q[31:24];
                  rdata_n   = {rdata_q[23:0], 8'h00};
                  cnt_n     = cnt_q + 2'd1;
               end
            end
         end
         default: state_n = S_CMD;
      endcase

      htrans_n   = (state_n == S_APH) ? TR_NONSEQ : TR_IDLE;
      busy_n     = (state_n != S_CMD);
      rx_ready_n = (state_n == S_CMD) || (state_n == S_ADDR) || (state_n == S_WDATA);
   end

endmodule

// File: tb/tb_ahb_lite_uart_master.sv
// Self-checking bench for ahb_lite_uart_master: byte-level host driver, AHB slave model and
// scoreboard queues for expected bus transfers and response bytes.
module tb_ahb_lite_uart_master;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
   } bus_t;

   logic        HCLK, HRESETn;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [2:0]  HBURST, HSIZE;
   logic        HMASTLOCK, HWRITE, HREADY, HRESP;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic [7:0]  RX_DATA, TX_DATA;
   logic        RX_VALID, RX_READY, TX_VALID, TX_READY, BUSY;

   int checks = 0;
   int failures = 0;

   int          s_ws = 0;
   logic        s_err = 1'b0;
   logic [31:0] s_rdata = 32'd0;
   int          dph_left = 0;
   int          held_bad = 0;

   bus_t       obs_q[$];
   bus_t       exp_bus_q[$];
   logic [7:0] exp_tx_q[$];
   logic [7:0] got_q[$];
   logic [7:0] frame_q[$];

   ahb_lite_uart_master #(.TIMEOUT_CYCLES(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
      .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .RX_READY(RX_READY), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .BUSY(BUSY)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // AHB slave model: records each NONSEQ address phase, then waits s_ws cycles before completing
   initial begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = 32'hA5A5A5A5;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            dph_left = 0;
            HREADY   = 1'b1;
            HRESP    = 1'b0;
         end else if (dph_left > 1) begin
            dph_left--;
            HREADY = 1'b0;
            HRESP  = s_err;
            HRDATA = 32'hA5A5A5A5;
         end else if (dph_left == 1) begin
            dph_left = 0;
            HREADY   = 1'b1;
            HRESP    = s_err;
            HRDATA   = s_rdata;
         end else begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
            HRDATA = 32'hA5A5A5A5;
            if (HTRANS == 2'b10) begin
               obs_q.push_back('{addr: HADDR, wr: HWRITE, wdata: HWDATA});
               dph_left = s_ws + 1;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge HCLK);
      while (!RX_READY && n < 200) begin
         @(negedge HCLK);
         n++;
      end
      if (!RX_READY) begin
         checks++;
         failures++;
         $display("FAIL rx_ready_wait: RX_READY=%0b required 1 for byte %02h", RX_READY, b);
      end else begin
         RX_DATA  = b;
         RX_VALID = 1'b1;
         @(negedge HCLK);
         RX_VALID = 1'b0;
         RX_DATA  = 8'h00;
      end
   endtask

   task automatic send_frame();
      foreach (frame_q[i]) send_byte(frame_q[i]);
   endtask

   task automatic get_tx(input int n, input bit toggle);
      int cyc = 0;
      bit holding = 0;
      logic [7:0] held = 8'h00;
      got_q.delete();
      held_bad = 0;
      while (got_q.size() < n && cyc < 500) begin
         @(negedge HCLK);
         cyc++;
         TX_READY = toggle ? ~TX_READY : 1'b1;
         if (TX_VALID) begin
            if (holding && TX_DATA !== held) held_bad++;
            if (TX_READY) begin
               got_q.push_back(TX_DATA);
               holding = 0;
            end else begin
               holding = 1;
               held    = TX_DATA;
            end
         end
      end
      @(negedge HCLK);
      TX_READY = 1'b0;
      repeat (4) @(negedge HCLK);
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans: got %0h want 0", HTRANS); end
      checks++; if (HADDR !== 32'd0) begin failures++; $display("FAIL rst_haddr: got %08h want 0", HADDR); end
      checks++; if (HWDATA !== 32'd0) begin failures++; $display("FAIL rst_hwdata: got %08h want 0", HWDATA); end
      checks++; if (HWRITE !== 1'b0) begin failures++; $display("FAIL rst_hwrite: got %0b want 0", HWRITE); end
      checks++; if (TX_VALID !== 1'b0 || TX_DATA !== 8'h00) begin failures++; $display("FAIL rst_tx: got v=%0b d=%02h want 0/00", TX_VALID, TX_DATA); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b want 0", BUSY); end
      checks++; if (RX_READY !== 1'b1) begin failures++; $display("FAIL rst_rx_ready: got %0b want 1", RX_READY); end
      checks++; if ({HBURST, HMASTLOCK, HPROT, HSIZE} !== {3'b000, 1'b0, 4'b0011, 3'b010}) begin
         failures++; $display("FAIL rst_consts: got %0h %0b %0h %0h want 0 0 3 2", HBURST, HMASTLOCK, HPROT, HSIZE);
      end
      HRESETn = 1'b1;
      @(negedge HCLK);
   endtask

   task automatic test_write();
      s_ws = 0; s_err = 1'b0;
      obs_q.delete(); exp_tx_q.delete();
      exp_bus_q.push_back('{addr: 32'h10, wr: 1'b1, wdata: 32'hDEADBEEF});
      exp_tx_q.push_back(8'h4B);
      frame_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_frame();
      get_tx(1, 1'b0);
      checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL wr_nonseq_count: got %0d want 1", obs_q.size()); end
      while (obs_q.size() > 0 && exp_bus_q.size() > 0) begin
         bus_t o = obs_q.pop_front();
         bus_t e = exp_bus_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL wr_bus: got %08h/%0b/%08h want %08h/%0b/%08h", o.addr, o.wr, o.wdata, e.addr, e.wr, e.wdata); end
      end
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL wr_tx_count: got %0d want 1", got_q.size()); end
      foreach (got_q[i]) if (exp_tx_q.size() > 0) begin
         logic [7:0] e = exp_tx_q.pop_front();
         checks++; if (got_q[i] !== e) begin failures++; $display("FAIL wr_tx_byte: got %02h want %02h", got_q[i], e); end
      end
      checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL wr_idle: got v=%0b busy=%0b want 0/0", TX_VALID, BUSY); end
   endtask

   task automatic test_read_wait();
      s_ws = 3; s_err = 1'b0; s_rdata = 32'h12345678;
      obs_q.delete(); exp_tx_q.delete();
      exp_tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
      frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h13};
      send_frame();
      get_tx(4, 1'b0);
      checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL rd_nonseq_count: got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         bus_t o = obs_q.pop_front();
         checks++; if (o.addr !== 32'h10 || o.wr !== 1'b0) begin failures++; $display("FAIL rd_bus: got %08h/%0b want 00000010/0", o.addr, o.wr); end
      end
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL rd_tx_count: got %0d want 4", got_q.size()); end
      foreach (got_q[i]) if (exp_tx_q.size() > 0) begin
         logic [7:0] e = exp_tx_q.pop_front();
         checks++; if (got_q[i] !== e) begin failures++; $display("FAIL rd_tx_byte%0d: got %02h want %02h", i, got_q[i], e); end
      end
   endtask

   task automatic test_error();
      s_ws = 1; s_err = 1'b1; s_rdata = 32'h55AA55AA;
      obs_q.delete();
      frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
      send_frame();
      get_tx(2, 1'b0);
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL err_tx_count: got %0d want 1", got_q.size()); end
      if (got_q.size() > 0) begin
         checks++; if (got_q[0] !== 8'h45) begin failures++; $display("FAIL err_tx_byte: got %02h want 45", got_q[0]); end
      end
      checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL err_nonseq_count: got %0d want 1", obs_q.size()); end
      s_ws = 0; s_err = 1'b0; s_rdata = 32'hCAFEF00D;
      obs_q.delete(); exp_tx_q.delete();
      exp_tx_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
      frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h24};
      send_frame();
      get_tx(4, 1'b0);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL err_next_count: got %0d want 4", got_q.size()); end
      foreach (got_q[i]) if (exp_tx_q.size() > 0) begin
         logic [7:0] e = exp_tx_q.pop_front();
         checks++; if (got_q[i] !== e) begin failures++; $display("FAIL err_next_byte%0d: got %02h want %02h", i, got_q[i], e); end
      end
      if (obs_q.size() > 0) begin
         bus_t o = obs_q.pop_front();
         checks++; if (o.addr !== 32'h24) begin failures++; $display("FAIL err_next_addr: got %08h want 00000024", o.addr); end
      end
   endtask

   task automatic test_timeout();
      int nonseq = 0, txv = 0;
      s_ws = 0; s_err = 1'b0; s_rdata = 32'h0BADF00D;
      obs_q.delete();
      frame_q = '{8'h52, 8'h00, 8'h00};
      send_frame();
      repeat (60) begin
         @(negedge HCLK);
         if (HTRANS == 2'b10) nonseq++;
         if (TX_VALID) txv++;
      end
      checks++; if (nonseq != 0 || obs_q.size() != 0) begin failures++; $display("FAIL tmo_no_xfer: got %0d nonseq cycles want 0", nonseq); end
      checks++; if (txv != 0) begin failures++; $display("FAIL tmo_no_tx: got %0d tx cycles want 0", txv); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL tmo_busy: got %0b want 0", BUSY); end
      exp_tx_q.delete();
      exp_tx_q = '{8'h0B, 8'hAD, 8'hF0, 8'h0D};
      frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h30};
      send_frame();
      get_tx(4, 1'b0);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL tmo_next_count: got %0d want 4", got_q.size()); end
      foreach (got_q[i]) if (exp_tx_q.size() > 0) begin
         logic [7:0] e = exp_tx_q.pop_front();
         checks++; if (got_q[i] !== e) begin failures++; $display("FAIL tmo_next_byte%0d: got %02h want %02h", i, got_q[i], e); end
      end
      if (obs_q.size() > 0) begin
         bus_t o = obs_q.pop_front();
         checks++; if (o.addr !== 32'h30) begin failures++; $display("FAIL tmo_next_addr: got %08h want 00000030", o.addr); end
      end
   endtask

   task automatic test_drop_toggle();
      s_ws = 0; s_err = 1'b0; s_rdata = 32'h89ABCDEF;
      obs_q.delete();
      send_byte(8'h41);
      repeat (3) @(negedge HCLK);
      checks++; if (BUSY !== 1'b0 || TX_VALID !== 1'b0) begin failures++; $display("FAIL drop_idle: got busy=%0b v=%0b want 0/0", BUSY, TX_VALID); end
      exp_tx_q.delete();
      exp_tx_q = '{8'h89, 8'hAB, 8'hCD, 8'hEF};
      frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h44};
      send_frame();
      get_tx(4, 1'b1);
      checks++; if (got_q.size() != 4) begin failures++; $display("FAIL tog_tx_count: got %0d want 4", got_q.size()); end
      foreach (got_q[i]) if (exp_tx_q.size() > 0) begin
         logic [7:0] e = exp_tx_q.pop_front();
         checks++; if (got_q[i] !== e) begin failures++; $display("FAIL tog_tx_byte%0d: got %02h want %02h", i, got_q[i], e); end
      end
      checks++; if (held_bad != 0) begin failures++; $display("FAIL tog_held: got %0d unstable cycles want 0", held_bad); end
      checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL tog_nonseq_count: got %0d want 1", obs_q.size()); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      s_ws = 20; s_err = 1'b0; s_rdata = 32'h77777777;
      obs_q.delete();
      frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h50};
      send_frame();
      while (obs_q.size() == 0 && n < 100) begin
         @(negedge HCLK);
         n++;
      end
      checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL mid_aph: got %0d address phases want 1", obs_q.size()); end
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b0;
      #1;
      checks++; if (HTRANS !== 2'b00 || TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
         failures++; $display("FAIL mid_rst_outputs: got htrans=%0h v=%0b busy=%0b want 0/0/0", HTRANS, TX_VALID, BUSY);
      end
      checks++; if (HADDR !== 32'd0 || HWDATA !== 32'd0) begin failures++; $display("FAIL mid_rst_bus: got %08h/%08h want 0/0", HADDR, HWDATA); end
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      s_ws = 0;
      obs_q.delete(); exp_bus_q.delete();
      exp_bus_q.push_back('{addr: 32'h60, wr: 1'b1, wdata: 32'h11223344});
      frame_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h63, 8'h11, 8'h22, 8'h33, 8'h44};
      send_frame();
      get_tx(1, 1'b0);
      checks++; if (got_q.size() != 1 || got_q[0] !== 8'h4B) begin failures++; $display("FAIL mid_next_tx: got %0d bytes want one 4B", got_q.size()); end
      checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL mid_next_count: got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         bus_t o = obs_q.pop_front();
         bus_t e = exp_bus_q.pop_front();
         checks++; if (o !== e) begin failures++; $display("FAIL mid_next_bus: got %08h/%0b/%08h want %08h/%0b/%08h", o.addr, o.wr, o.wdata, e.addr, e.wr, e.wdata); end
      end
   endtask

   initial begin
      HRESETn  = 1'b0;
      RX_DATA  = 8'h00;
      RX_VALID = 1'b0;
      TX_READY = 1'b0;
      test_reset();
      test_write();
      test_read_wait();
      test_error();
      test_timeout();
      test_drop_toggle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
